str_vga_gen_param: RTL and testbench

//  Parametrised stream-VGA timing generator. Produces the packed stream {activevideo, vsync, hsync, y, x}

---
 rtl/str_vga_pkg.sv | 45 ++++
 rtl/str_vga_axis_cnt.sv | 67 ++++++
 rtl/str_vga_gen_param.sv | 161 ++++++++++++++++
 tb/tb_str_vga_gen_param.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/str_vga_pkg.sv
// Shared definitions for the stream-VGA timing generator: default 640x480@60
// timing, stream field offsets as functions of the coordinate width, and the
// run/stop FSM encoding.
package str_vga_pkg;

    // Default 640x480@60 timing (25.175 MHz pixel clock)
    localparam int DEF_CW       = 10;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Stream layout: {activevideo, vsync, hsync, y[CW], x[CW]}
    function automatic int Y_LSB(input int cw);
        return cw;
    endfunction

    // x occupies the cw bits directly beneath y
    function automatic int X_LSB(input int cw);
        return Y_LSB(cw) - cw;
    endfunction

    function automatic int HS_BIT(input int cw);
        return 2 * cw;
    endfunction

    function automatic int VS_BIT(input int cw);
        return 2 * cw + 1;
    endfunction

    function automatic int AV_BIT(input int cw);
        return 2 * cw + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } vga_state_e;

endpackage

// File: rtl/str_vga_axis_cnt.sv
// One timing axis (horizontal or vertical). Holds the pixel/line count and
// reports, for the count being loaded at this edge, whether it lies in the
// sync pulse and in the visible region, so the parent can register the whole
// stream word from a single consistent position.
module str_vga_axis_cnt #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [CW-1:0] o_cnt_nxt,
    output logic          o_wrap,
    output logic          o_sync,
    output logic          o_active
);

    localparam int            TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int            SYNC_START = ACTIVE + FP;
    localparam int            SYNC_END   = SYNC_START + SYNC;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_in_sync;

    // Next count: clear wins, otherwise increment with wrap at the last position
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            if (r_cnt == LAST) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Sync and visible-region decode of the upcoming count
    always_comb begin
        w_in_sync = (int'(w_cnt_nxt) >= SYNC_START) && (int'(w_cnt_nxt) < SYNC_END);
        o_sync    = w_in_sync ? POL : ~POL;
        o_active  = (int'(w_cnt_nxt) < ACTIVE);
    end

    // Count register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt_nxt = w_cnt_nxt;
    assign o_wrap    = (r_cnt == LAST);

endmodule

// File: rtl/str_vga_gen_param.sv
// Parametrised stream-VGA timing generator with run/stop control that always
// finishes the current frame before going idle, plus frame/line strobes.
// Optional feature macro STR_VGA_CE_EN: adds the px_ce port so the generator
// advances only on clock-enable cycles (px_clk may then be a fast system clock).
module str_vga_gen_param
    import str_vga_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic            px_clk,
    input  logic            rst_n,
    input  logic            run,
`ifdef STR_VGA_CE_EN
    input  logic            px_ce,
`endif
    output logic [2*CW+2:0] strVGA,
    output logic            sof,
    output logic            eol,
    output logic            busy
);

    localparam int            SW          = 2 * CW + 3;
    localparam int            H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    // Idle stream: not active, both syncs at their inactive level, x = y = 0
    localparam logic [SW-1:0] STREAM_IDLE = SW'({1'b0, ~VS_POL, ~HS_POL}) << HS_BIT(CW);

    logic          w_adv;
    vga_state_e    r_state;
    vga_state_e    w_state_nxt;
    logic          w_h_inc, w_h_clr, w_h_wrap, w_h_sync, w_h_active;
    logic          w_v_inc, w_v_clr, w_v_wrap, w_v_sync, w_v_active;
    logic [CW-1:0] w_h_nxt, w_v_nxt;
    logic          w_frame_end;
    logic [SW-1:0] w_stream_nxt;
    logic          w_sof_nxt, w_eol_nxt;
    logic [SW-1:0] r_stream;
    logic          r_sof, r_eol, r_busy;

`ifdef STR_VGA_CE_EN
    assign w_adv = px_ce;
`else
    assign w_adv = 1'b1;
`endif

    // Counters sit at zero while idle; v advances when h wraps
    assign w_h_inc     = w_adv && (r_state != IDLE);
    assign w_h_clr     = w_adv && (r_state == IDLE);
    assign w_v_inc     = w_h_inc && w_h_wrap;
    assign w_v_clr     = w_h_clr;
    assign w_frame_end = w_h_wrap && w_v_wrap;

    str_vga_axis_cnt #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
    ) u_hcnt (
        .i_clk    (px_clk),
        .i_rst_n  (rst_n),
        .i_inc    (w_h_inc),
        .i_clr    (w_h_clr),
        .o_cnt_nxt(w_h_nxt),
        .o_wrap   (w_h_wrap),
        .o_sync   (w_h_sync),
        .o_active (w_h_active)
    );

    str_vga_axis_cnt #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
    ) u_vcnt (
        .i_clk    (px_clk),
        .i_rst_n  (rst_n),
        .i_inc    (w_v_inc),
        .i_clr    (w_v_clr),
        .o_cnt_nxt(w_v_nxt),
        .o_wrap   (w_v_wrap),
        .o_sync   (w_v_sync),
        .o_active (w_v_active)
    );

    // Run/stop FSM: a stop request only takes effect at the last pixel of a frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else if (w_frame_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else if (w_frame_end) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Assemble the stream word and strobes for the pixel presented after this edge
    always_comb begin
        w_stream_nxt                       = '0;
        w_stream_nxt[X_LSB(CW) +: CW]      = w_h_nxt;
        w_stream_nxt[Y_LSB(CW) +: CW]      = w_v_nxt;
        w_stream_nxt[HS_BIT(CW)]           = w_h_sync;
        w_stream_nxt[VS_BIT(CW)]           = w_v_sync;
        w_stream_nxt[AV_BIT(CW)]           = w_h_active && w_v_active && (w_state_nxt != IDLE);
        w_sof_nxt = (w_state_nxt == RUN) && (w_h_nxt == '0) && (w_v_nxt == '0);
        w_eol_nxt = (w_state_nxt != IDLE) && (w_h_nxt == H_LAST);
    end

    // State and output registers; strobes last a single clock even when advances are sparse
    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_stream <= STREAM_IDLE;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_adv) begin
            r_state  <= w_state_nxt;
            r_stream <= w_stream_nxt;
            r_sof    <= w_sof_nxt;
            r_eol    <= w_eol_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end else begin
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
        end
    end

    assign strVGA = r_stream;
    assign sof    = r_sof;
    assign eol    = r_eol;
    assign busy   = r_busy;

endmodule

// File: tb/tb_str_vga_gen_param.sv
// Directed bench for str_vga_gen_param: a default 640x480 instance for the
// first line, and a tiny 8x6 instance (active-high syncs) for frame wrap,
// stop/restart and mid-frame reset. Clock-enable checks build with STR_VGA_CE_EN.
module tb_str_vga_gen_param;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic        run_d;
    logic        run_s;
`ifdef STR_VGA_CE_EN
    logic        px_ce;
`endif
    logic [22:0] vga_d;
    logic        sof_d, eol_d, busy_d;
    logic [10:0] vga_s;
    logic        sof_s, eol_s, busy_s;

    int n_vec    = 0;
    int n_miscmp = 0;

    always #5 px_clk = ~px_clk;

    str_vga_gen_param u_dut_d (
        .px_clk(px_clk),
        .rst_n (rst_n),
        .run   (run_d),
`ifdef STR_VGA_CE_EN
        .px_ce (px_ce),
`endif
        .strVGA(vga_d),
        .sof   (sof_d),
        .eol   (eol_d),
        .busy  (busy_d)
    );

    str_vga_gen_param #(
        .CW(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_s (
        .px_clk(px_clk),
        .rst_n (rst_n),
        .run   (run_s),
`ifdef STR_VGA_CE_EN
        .px_ce (px_ce),
`endif
        .strVGA(vga_s),
        .sof   (sof_s),
        .eol   (eol_s),
        .busy  (busy_s)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge px_clk);
        #1;
    endtask

    // 640x480 timing, active-low syncs: hsync x 656..751, vsync y 490..491
    function automatic logic [22:0] exp_d(input int x, input int y, input bit on);
        logic av, vs, hs;
        av = on && (x < 640) && (y < 480);
        vs = !((y >= 490) && (y < 492));
        hs = !((x >= 656) && (x < 752));
        return {av, vs, hs, 10'(y), 10'(x)};
    endfunction

    // 8x6 timing, active-high syncs: hsync x 5..6, vsync y 4, active x<4 y<3
    function automatic logic [10:0] exp_s(input int x, input int y, input bit on);
        logic av, vs, hs;
        av = on && (x < 4) && (y < 3);
        vs = (y == 4);
        hs = (x == 5) || (x == 6);
        return {av, vs, hs, 4'(y), 4'(x)};
    endfunction

    initial begin
        rst_n = 1'b0;
        run_d = 1'b0;
        run_s = 1'b0;
`ifdef STR_VGA_CE_EN
        px_ce = 1'b1;
`endif
        repeat (3) step();

        // Reset values
        check_val("rst_stream_d", 32'(vga_d), 32'h0030_0000);
        check_val("rst_flags_d", 32'({sof_d, eol_d, busy_d}), 32'd0);
        check_val("rst_stream_s", 32'(vga_s), 32'd0);
        check_val("rst_flags_s", 32'({sof_s, eol_s, busy_s}), 32'd0);

        // Idle with run low holds the reset value
        rst_n = 1'b1;
        step();
        check_val("idle_stream_d", 32'(vga_d), 32'h0030_0000);
        check_val("idle_busy_d", 32'(busy_d), 32'd0);

        // Start: pixel (0,0) with sof
        run_d = 1'b1;
        step();
        check_val("start_stream_d", 32'(vga_d), 32'(exp_d(0, 0, 1'b1)));
        check_val("start_flags_d", 32'({sof_d, eol_d, busy_d}), 32'b101);

        // First line: hsync window, active region, eol at 799
        for (int x = 1; x < 800; x++) begin
            step();
            check_val("line0_stream_d", 32'(vga_d), 32'(exp_d(x, 0, 1'b1)));
            check_val("line0_flags_d", 32'({sof_d, eol_d, busy_d}), 32'({1'b0, (x == 799), 1'b1}));
        end
        step();
        check_val("line1_stream_d", 32'(vga_d), 32'(exp_d(0, 1, 1'b1)));
        check_val("line1_flags_d", 32'({sof_d, eol_d, busy_d}), 32'b001);

        // Small instance: four back-to-back frames with stop/restart and a final stop
        run_s = 1'b1;
        for (int k = 0; k < 192; k++) begin
            int x, y;
            step();
            x = k % 8;
            y = (k / 8) % 6;
            check_val("frame_stream_s", 32'(vga_s), 32'(exp_s(x, y, 1'b1)));
            check_val("frame_flags_s", 32'({sof_s, eol_s, busy_s}),
                      32'({(x == 0) && (y == 0), (x == 7), 1'b1}));
            if (k == 104) run_s = 1'b0;
            if (k == 120) run_s = 1'b1;
            if (k == 152) run_s = 1'b0;
        end
        step();
        check_val("stopped_stream_s", 32'(vga_s), 32'd0);
        check_val("stopped_flags_s", 32'({sof_s, eol_s, busy_s}), 32'd0);
        step();
        check_val("idle_hold_s", 32'(vga_s), 32'd0);
        check_val("idle_hold_busy_s", 32'(busy_s), 32'd0);

        // Mid-frame reset
        run_s = 1'b1;
        repeat (4) step();
        check_val("pre_rst_stream_s", 32'(vga_s), 32'(exp_s(3, 0, 1'b1)));
        rst_n = 1'b0;
        step();
        check_val("midrst_stream_s", 32'(vga_s), 32'd0);
        check_val("midrst_flags_s", 32'({sof_s, eol_s, busy_s}), 32'd0);
        check_val("midrst_stream_d", 32'(vga_d), 32'h0030_0000);
        check_val("midrst_flags_d", 32'({sof_d, eol_d, busy_d}), 32'd0);
        rst_n = 1'b1;
        run_d = 1'b0;

`ifdef STR_VGA_CE_EN
        // Advance every second clock: each x held two cycles, strobes one cycle
        for (int c = 0; c < 16; c++) begin
            px_ce = (c % 2 == 0);
            step();
            check_val("ce_stream_s", 32'(vga_s), 32'(exp_s(c / 2, 0, 1'b1)));
            check_val("ce_flags_s", 32'({sof_s, eol_s, busy_s}),
                      32'({(c == 0), (c == 14), 1'b1}));
        end
        // Reset applies even without an enable
        px_ce = 1'b0;
        rst_n = 1'b0;
        step();
        check_val("ce_rst_stream_s", 32'(vga_s), 32'd0);
        check_val("ce_rst_busy_s", 32'(busy_s), 32'd0);
        rst_n = 1'b1;
        px_ce = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
